// File: rtl/rv32i_control_unit.sv
// rv32i_control_unit
// Decode-stage instruction decoder for the RV32I pipeline. It turns the
// opcode/funct3/funct7 fields into every datapath control for execute,
// memory and writeback.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   OP, Func3, Func7  instr[6:0], instr[14:12], instr[31:25]
//   REG_W_En, MEM_W_En, Jump_En, Branch_En   enables
//   MEM_Control       access size/sign (follows funct3 for loads/stores)
//   ALU_Control       ALU operation
//   Imm_Type_Sel      immediate format
//   Branch_Src_Sel    jump/branch target base (PC or register)
//   ALU_SrcA_Sel, ALU_SrcB_Sel, Result_Src_Sel   operand/result muxes
//   Illegal_Instr     current encoding is illegal (combinational)
//   Illegal_Seen      sticky: an illegal encoding was seen since reset
//
// Decode is purely combinational. Any unsupported encoding collapses to a
// bubble, so it has no architectural side effect.
module rv32i_control_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OP,
    input  logic [2:0] Func3,
    input  logic [6:0] Func7,
    output logic       REG_W_En,
    output logic       MEM_W_En,
    output logic       Jump_En,
    output logic       Branch_En,
    output logic [2:0] MEM_Control,
    output logic [3:0] ALU_Control,
    output logic [2:0] Imm_Type_Sel,
    output logic       Branch_Src_Sel,
    output logic       ALU_SrcA_Sel,
    output logic       ALU_SrcB_Sel,
    output logic [1:0] Result_Src_Sel,
    output logic       Illegal_Instr,
    output logic       Illegal_Seen
);

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,
                           ALU_XOR = 4'd3,  ALU_SRL  = 4'd4,  ALU_SRA  = 4'd5,
                           ALU_OR  = 4'd6,  ALU_AND  = 4'd7,  ALU_LUI  = 4'd8,
                           ALU_BEQ = 4'd9,  ALU_BNE  = 4'd10, ALU_BLT  = 4'd11,
                           ALU_BGE = 4'd12, ALU_BLTU = 4'd13, ALU_BGEU = 4'd14;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2,
                           IMM_U = 3'd3, IMM_J = 3'd4;

    localparam logic [2:0] MEM_BYTE = 3'b000;

    localparam logic       BRANCH_PC = 1'b0, BRANCH_REG = 1'b1;
    localparam logic       SRCA_REG  = 1'b0, SRCA_PC    = 1'b1;
    localparam logic       SRCB_REG  = 1'b0, SRCB_IMM   = 1'b1;
    localparam logic [1:0] RESULT_ALU = 2'd0, RESULT_PC4 = 2'd1;

    // ALU op shared by register and immediate arithmetic for the func3
    // values whose meaning does not depend on funct7.
    function automatic logic [3:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_BLT;
            3'b011:  arith_op = ALU_BLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    logic illegal;

    always_comb begin
        REG_W_En       = 1'b0;
        MEM_W_En       = 1'b0;
        Jump_En        = 1'b0;
        Branch_En      = 1'b0;
        MEM_Control    = MEM_BYTE;
        ALU_Control    = ALU_ADD;
        Imm_Type_Sel   = IMM_I;
        Branch_Src_Sel = BRANCH_PC;
        ALU_SrcA_Sel   = SRCA_REG;
        ALU_SrcB_Sel   = SRCB_REG;
        Result_Src_Sel = RESULT_ALU;
        illegal        = 1'b0;

        case (OP)
            OPC_R: begin
                REG_W_En = 1'b1;
                if (Func7 == F7_BASE)
                    ALU_Control = arith_op(Func3);
                else if (Func7 == F7_ALT && Func3 == 3'b000)
                    ALU_Control = ALU_SUB;
                else if (Func7 == F7_ALT && Func3 == 3'b101)
                    ALU_Control = ALU_SRA;
                else
                    illegal = 1'b1;
            end
            OPC_IMM: begin
                REG_W_En     = 1'b1;
                ALU_SrcB_Sel = SRCB_IMM;
                ALU_Control  = arith_op(Func3);
                // Shift-immediates reuse funct7 as the shift-type field.
                if (Func3 == 3'b001 && Func7 != F7_BASE)
                    illegal = 1'b1;
                if (Func3 == 3'b101) begin
                    if (Func7 == F7_ALT)
                        ALU_Control = ALU_SRA;
                    else if (Func7 != F7_BASE)
                        illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                REG_W_En     = 1'b1;
                MEM_Control  = Func3;
                ALU_SrcB_Sel = SRCB_IMM;
                illegal      = (Func3 == 3'b011) || (Func3 == 3'b110) || (Func3 == 3'b111);
            end
            OPC_STORE: begin
                MEM_W_En     = 1'b1;
                MEM_Control  = Func3;
                Imm_Type_Sel = IMM_S;
                ALU_SrcB_Sel = SRCB_IMM;
                illegal      = Func3[2] || (Func3 == 3'b011);
            end
            OPC_BR: begin
                Branch_En    = 1'b1;
                Imm_Type_Sel = IMM_B;
                case (Func3)
                    3'b000:  ALU_Control = ALU_BEQ;
                    3'b001:  ALU_Control = ALU_BNE;
                    3'b100:  ALU_Control = ALU_BLT;
                    3'b101:  ALU_Control = ALU_BGE;
                    3'b110:  ALU_Control = ALU_BLTU;
                    3'b111:  ALU_Control = ALU_BGEU;
                    default: illegal     = 1'b1;
                endcase
            end
            OPC_JAL: begin
                REG_W_En       = 1'b1;
                Jump_En        = 1'b1;
                Imm_Type_Sel   = IMM_J;
                Result_Src_Sel = RESULT_PC4;
            end
            OPC_JALR: begin
                REG_W_En       = 1'b1;
                Jump_En        = 1'b1;
                Branch_Src_Sel = BRANCH_REG;
                ALU_SrcB_Sel   = SRCB_IMM;
                Result_Src_Sel = RESULT_PC4;
                illegal        = (Func3 != 3'b000);
            end
            OPC_LUI: begin
                REG_W_En     = 1'b1;
                ALU_Control  = ALU_LUI;
                Imm_Type_Sel = IMM_U;
                ALU_SrcB_Sel = SRCB_IMM;
            end
            OPC_AUIPC: begin
                REG_W_En     = 1'b1;
                Imm_Type_Sel = IMM_U;
                ALU_SrcA_Sel = SRCA_PC;
                ALU_SrcB_Sel = SRCB_IMM;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal encodings become a bubble: nothing may write or redirect.
        if (illegal) begin
            REG_W_En       = 1'b0;
            MEM_W_En       = 1'b0;
            Jump_En        = 1'b0;
            Branch_En      = 1'b0;
            MEM_Control    = MEM_BYTE;
            ALU_Control    = ALU_ADD;
            Imm_Type_Sel   = IMM_I;
            Branch_Src_Sel = BRANCH_PC;
            ALU_SrcA_Sel   = SRCA_REG;
            ALU_SrcB_Sel   = SRCB_REG;
            Result_Src_Sel = RESULT_ALU;
        end
    end

    assign Illegal_Instr = illegal;

    // Reset wins over a simultaneous illegal instruction.
    always_ff @(posedge CLK) begin
        if (RST)
            Illegal_Seen <= 1'b0;
        else if (illegal)
            Illegal_Seen <= 1'b1;
    end

endmodule

// File: tb/tb_rv32i_control_unit.sv
// Self-checking bench for rv32i_control_unit: directed encodings with
// constant expectations, sticky-flag sequencing, and randomized encodings
// checked against a table-driven model of the decode rules.
module tb_rv32i_control_unit;

    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       jump;
        logic       branch;
        logic [2:0] mem;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       bsrc;
        logic       srca;
        logic       srcb;
        logic [1:0] res;
        logic       ill;
    } dec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] OP = '0;
    logic [2:0] Func3 = '0;
    logic [6:0] Func7 = '0;
    logic       REG_W_En, MEM_W_En, Jump_En, Branch_En;
    logic [2:0] MEM_Control;
    logic [3:0] ALU_Control;
    logic [2:0] Imm_Type_Sel;
    logic       Branch_Src_Sel, ALU_SrcA_Sel, ALU_SrcB_Sel;
    logic [1:0] Result_Src_Sel;
    logic       Illegal_Instr, Illegal_Seen;

    int vectors = 0;
    int miscompares = 0;

    rv32i_control_unit dut (
        .CLK(CLK), .RST(RST), .OP(OP), .Func3(Func3), .Func7(Func7),
        .REG_W_En(REG_W_En), .MEM_W_En(MEM_W_En), .Jump_En(Jump_En),
        .Branch_En(Branch_En), .MEM_Control(MEM_Control), .ALU_Control(ALU_Control),
        .Imm_Type_Sel(Imm_Type_Sel), .Branch_Src_Sel(Branch_Src_Sel),
        .ALU_SrcA_Sel(ALU_SrcA_Sel), .ALU_SrcB_Sel(ALU_SrcB_Sel),
        .Result_Src_Sel(Result_Src_Sel), .Illegal_Instr(Illegal_Instr),
        .Illegal_Seen(Illegal_Seen)
    );

    always #5 CLK = ~CLK;

    dec_t got;
    assign got = '{REG_W_En, MEM_W_En, Jump_En, Branch_En, MEM_Control, ALU_Control,
                   Imm_Type_Sel, Branch_Src_Sel, ALU_SrcA_Sel, ALU_SrcB_Sel,
                   Result_Src_Sel, Illegal_Instr};

    // Reference decode written directly from the instruction-set rules.
    function automatic dec_t model(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int r_alu [8];
        int b_alu [8];
        dec_t d;
        r_alu = '{0, 2, 11, 13, 3, 4, 6, 7};
        b_alu = '{9, 10, -1, -1, 11, 12, 13, 14};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d  = '0;
        if (op == 7'h33) begin
            d.reg_w = 1;
            if (f7 == 0) d.alu = 4'(r_alu[f3]);
            else if (f7 == 7'h20 && f3 == 0) d.alu = 1;
            else if (f7 == 7'h20 && f3 == 5) d.alu = 5;
            else d.ill = 1;
        end else if (op == 7'h13) begin
            d.reg_w = 1; d.srcb = 1;
            d.alu = 4'(r_alu[f3]);
            if (f3 == 1 && f7 != 0) d.ill = 1;
            if (f3 == 5) begin
                if (f7 == 7'h20) d.alu = 5;
                else if (f7 != 0) d.ill = 1;
            end
        end else if (op == 7'h03) begin
            d.reg_w = 1; d.mem = f3; d.srcb = 1;
            d.ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end else if (op == 7'h23) begin
            d.mem_w = 1; d.mem = f3; d.imm = 1; d.srcb = 1;
            d.ill = (f3 > 2);
        end else if (op == 7'h63) begin
            d.branch = 1; d.imm = 2;
            if (b_alu[f3] < 0) d.ill = 1;
            else d.alu = 4'(b_alu[f3]);
        end else if (op == 7'h6F) begin
            d.reg_w = 1; d.jump = 1; d.imm = 4; d.res = 1;
        end else if (op == 7'h67) begin
            d.reg_w = 1; d.jump = 1; d.bsrc = 1; d.srcb = 1; d.res = 1;
            d.ill = (f3 != 0);
        end else if (op == 7'h37) begin
            d.reg_w = 1; d.alu = 8; d.imm = 3; d.srcb = 1;
        end else if (op == 7'h17) begin
            d.reg_w = 1; d.imm = 3; d.srca = 1; d.srcb = 1;
        end else begin
            d.ill = 1;
        end
        if (d.ill) begin
            d = '0;
            d.ill = 1;
        end
        return d;
    endfunction

    task automatic apply(input logic [31:0] ins);
        OP    = ins[6:0];
        Func3 = ins[14:12];
        Func7 = ins[31:25];
    endtask

    task automatic test_reset;
        @(negedge CLK);
        apply(32'h4087018F);   // illegal present during reset
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        apply(32'h408701B3);
        vectors++;
        if (Illegal_Seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_seen got=%0b want=0", Illegal_Seen);
        end
        @(posedge CLK); #1;
        vectors++;
        if (Illegal_Seen !== 1'b0) begin
            miscompares++;
            $display("FAIL legal_keeps_seen_clear got=%0b want=0", Illegal_Seen);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ins  [11];
        dec_t        want [11];
        string       name [11];
        ins[0]  = 32'h408701B3; name[0]  = "sub";   want[0]  = '{1,0,0,0,3'd0,4'd1, 3'd0,0,0,0,2'd0,0};
        ins[1]  = 32'h40872183; name[1]  = "lw";    want[1]  = '{1,0,0,0,3'd2,4'd0, 3'd0,0,0,1,2'd0,0};
        ins[2]  = 32'h408701A3; name[2]  = "sb";    want[2]  = '{0,1,0,0,3'd0,4'd0, 3'd1,0,0,1,2'd0,0};
        ins[3]  = 32'h408771E3; name[3]  = "bgeu";  want[3]  = '{0,0,0,1,3'd0,4'd14,3'd2,0,0,0,2'd0,0};
        ins[4]  = 32'h408701E7; name[4]  = "jalr";  want[4]  = '{1,0,1,0,3'd0,4'd0, 3'd0,1,0,1,2'd1,0};
        ins[5]  = 32'h408771EF; name[5]  = "jal";   want[5]  = '{1,0,1,0,3'd0,4'd0, 3'd4,0,0,0,2'd1,0};
        ins[6]  = 32'h40877197; name[6]  = "auipc"; want[6]  = '{1,0,0,0,3'd0,4'd0, 3'd3,0,1,1,2'd0,0};
        ins[7]  = 32'h408771B7; name[7]  = "lui";   want[7]  = '{1,0,0,0,3'd0,4'd8, 3'd3,0,0,1,2'd0,0};
        ins[8]  = 32'h4087018F; name[8]  = "fence"; want[8]  = '{0,0,0,0,3'd0,4'd0, 3'd0,0,0,0,2'd0,1};
        ins[9]  = 32'h028701B3; name[9]  = "mul";   want[9]  = '{0,0,0,0,3'd0,4'd0, 3'd0,0,0,0,2'd0,1};
        // R-type with funct7=0100000 and funct3=011 has no legal meaning.
        ins[10] = 32'h408731B3; name[10] = "r_alt_f3_011"; want[10] = '{0,0,0,0,3'd0,4'd0,3'd0,0,0,0,2'd0,1};
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            apply(ins[i]);
            #1;
            vectors++;
            if (got !== want[i]) begin
                miscompares++;
                $display("FAIL dir_%s got=%h want=%h", name[i], got, want[i]);
            end
        end
    endtask

    task automatic test_sticky;
        // Clear, then one illegal edge sets the flag, legal edges keep it.
        @(negedge CLK); RST = 1'b1; apply(32'h408701B3);
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK); apply(32'h028701B3);
        @(posedge CLK); #1;
        vectors++;
        if (Illegal_Seen !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_set got=%0b want=1", Illegal_Seen);
        end
        @(negedge CLK); apply(32'h408771B7);
        @(posedge CLK); #1;
        vectors++;
        if (Illegal_Seen !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_hold got=%0b want=1", Illegal_Seen);
        end
        @(negedge CLK); apply(32'h4087018F); RST = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (Illegal_Seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority got=%0b want=0", Illegal_Seen);
        end
        vectors++;
        if (Illegal_Instr !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_during_reset got=%0b want=1", Illegal_Instr);
        end
        RST = 1'b0;
    endtask

    task automatic test_random;
        logic [6:0]  ops [12];
        logic [31:0] ins;
        logic        seen;
        dec_t        want;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17,
                7'h0F, 7'h73, 7'h00};
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ;
            endcase
            RST = ($urandom_range(0, 15) == 0);
            apply(ins);
            #1;
            want = model(ins);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL rand_decode ins=%h got=%h want=%h", ins, got, want);
            end
            seen = RST ? 1'b0 : (seen | want.ill);
            @(posedge CLK); #1;
            vectors++;
            if (Illegal_Seen !== seen) begin
                miscompares++;
                $display("FAIL rand_seen ins=%h got=%0b want=%0b", ins, Illegal_Seen, seen);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_sticky;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
